mux_arb_n: RTL and testbench

- Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Two select modes:
  - direct: external select, the same semantics as a plain 4:1 mux, generalised to N inputs and W bits.
  - round-robin: fair arbitration among the valid inputs.
- One output register stage.
- Sits between multiple producers (e.g. forwarding sources, memory request ports) and a single consumer in the pipeline.

---
 rtl/mux_arb_n_if.sv | 24 ++
 rtl/mux_arb_n.sv | 69 ++++++
 tb/tb_mux_arb_n.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: select controls plus producer and consumer valid/ready handshake bundle
interface mux_arb_n_if #(
  parameter int N = 4,
  parameter int W = 64,
  localparam int SEL_W = $clog2(N)
);
  logic mode;
  logic [SEL_W-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic [SEL_W-1:0] out_src;
  logic out_valid;
  logic out_ready;
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input in_ready, out_data, out_src, out_valid
  );
  modport slave (
    input mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-input registered mux with direct or round-robin select and valid/ready handshakes
module mux_arb_n #(
  parameter int N = 4,
  parameter int W = 64,
  localparam int SEL_W = $clog2(N)
) (
  input logic clk,
  input logic reset_n,
  mux_arb_n_if.slave bus
);
  logic load, gnt, xfer, valid_q, valid_d;
  logic [SEL_W-1:0] gnt_idx, ptr_q, ptr_d, src_q, src_d;
  logic [W-1:0] gnt_data, data_q, data_d;
  always_comb begin
    gnt = 1'b0;
    gnt_idx = '0;
    if (!bus.mode) begin
      for (int i = 0; i < N; i++)
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          gnt = 1'b1;
          gnt_idx = SEL_W'(i);
        end
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (bus.in_valid[i] && SEL_W'(i) < ptr_q) begin
          gnt = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      for (int i = N - 1; i >= 0; i--)
        if (bus.in_valid[i] && SEL_W'(i) >= ptr_q) begin
          gnt = 1'b1;
          gnt_idx = SEL_W'(i);
        end
    end
  end
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++)
      if (gnt_idx == SEL_W'(i)) gnt_data = bus.in_data[i*W +: W];
  end
  assign load = !valid_q || bus.out_ready;
  assign xfer = reset_n && load && gnt;
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) bus.in_ready[i] = xfer && gnt_idx == SEL_W'(i);
  end
  always_comb begin
    valid_d = load ? gnt : valid_q;
    data_d = xfer ? gnt_data : data_q;
    src_d = xfer ? gnt_idx : src_q;
    ptr_d = (xfer && bus.mode) ? ((gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
      src_q <= '0;
      ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_src = src_q;
endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: vector table plus scoreboard bench for the N=4 and N=3 arbiter builds
module tb_mux_arb_n;
  typedef struct {
    logic mode;
    logic [1:0] sel;
    logic [3:0] v;
    logic rdy;
    logic [3:0] exp_ir;
    logic exp_ov;
    logic [1:0] exp_src;
  } vec_t;
  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
  } beat_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  beat_t sb[$];
  logic [7:0] dat [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic prev_ov;
  mux_arb_n_if #(.N(4), .W(8)) b4 ();
  mux_arb_n_if #(.N(3), .W(8)) b3 ();
  mux_arb_n #(.N(4), .W(8)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));
  mux_arb_n #(.N(3), .W(8)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(logic mode, logic [1:0] sel, logic [3:0] v, logic rdy,
                              logic [3:0] ir, logic ov, logic [1:0] src);
    vec_t r;
    r.mode = mode; r.sel = sel; r.v = v; r.rdy = rdy;
    r.exp_ir = ir; r.exp_ov = ov; r.exp_src = src;
    return r;
  endfunction
  initial begin
    b4.mode = 1'b0; b4.sel = 2'd0; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
    b4.in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    b3.mode = 1'b0; b3.sel = 2'd0; b3.in_valid = 3'b000; b3.out_ready = 1'b1;
    b3.in_data = {8'h62, 8'h51, 8'h40};
    #1;
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_out_data", b4.out_data, 0);
    chk("rst_out_src", b4.out_src, 0);
    chk("rst_in_ready", b4.in_ready, 4'b0000);
    step();
    step();
    reset_n = 1'b1;
    vecs.push_back(mk(0, 0, 4'b1111, 1, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 1, 4'b0010, 1, 1));
    vecs.push_back(mk(0, 2, 4'b1111, 1, 4'b0100, 1, 2));
    vecs.push_back(mk(0, 3, 4'b1111, 1, 4'b1000, 1, 3));
    vecs.push_back(mk(0, 2, 4'b1011, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 0, 4'b1111, 1, 4'b0001, 1, 0));
    vecs.push_back(mk(1, 0, 4'b1111, 1, 4'b0010, 1, 1));
    vecs.push_back(mk(1, 0, 4'b1111, 1, 4'b0100, 1, 2));
    vecs.push_back(mk(1, 0, 4'b1111, 1, 4'b1000, 1, 3));
    vecs.push_back(mk(1, 0, 4'b1111, 1, 4'b0001, 1, 0));
    vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b1000, 1, 3));
    vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b0001, 1, 0));
    vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b1000, 1, 3));
    vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b0001, 1, 0));
    vecs.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 4'b1111, 1, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 1, 4'b0010, 1, 4'b0010, 1, 1));
    vecs.push_back(mk(1, 0, 4'b1111, 1, 4'b0010, 1, 1));
    vecs.push_back(mk(0, 0, 4'b1111, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0));
    prev_ov = 1'b0;
    foreach (vecs[k]) begin
      b4.mode = vecs[k].mode;
      b4.sel = vecs[k].sel;
      b4.in_valid = vecs[k].v;
      b4.out_ready = vecs[k].rdy;
      #1;
      chk($sformatf("v%0d_in_ready", k), b4.in_ready, vecs[k].exp_ir);
      if (prev_ov && vecs[k].rdy && sb.size() > 0) void'(sb.pop_front());
      if (vecs[k].exp_ir != 4'b0000) sb.push_back('{d: dat[vecs[k].exp_src], s: vecs[k].exp_src});
      step();
      chk($sformatf("v%0d_out_valid", k), b4.out_valid, vecs[k].exp_ov);
      if (b4.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL v%0d_scoreboard actual=beat required=none", k);
        end else begin
          chk($sformatf("v%0d_out_data", k), b4.out_data, sb[0].d);
          chk($sformatf("v%0d_out_src", k), b4.out_src, sb[0].s);
        end
      end
      prev_ov = vecs[k].exp_ov;
    end
    chk("sb_drained", sb.size(), 0);
    chk("hold_data_after_idle", b4.out_data, 8'hB1);
    chk("hold_src_after_idle", b4.out_src, 1);
    b4.mode = 1'b0; b4.sel = 2'd2; b4.in_valid = 4'b1111; b4.out_ready = 1'b0;
    step();
    chk("mid_pre_valid", b4.out_valid, 1);
    chk("mid_pre_data", b4.out_data, 8'hC2);
    b4.out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", b4.out_valid, 0);
    chk("mid_rst_out_data", b4.out_data, 0);
    chk("mid_rst_out_src", b4.out_src, 0);
    chk("mid_rst_in_ready", b4.in_ready, 4'b0000);
    step();
    b4.in_valid = 4'b0000;
    reset_n = 1'b1;
    step();
    chk("post_rst_no_beat", b4.out_valid, 0);
    b4.mode = 1'b1; b4.in_valid = 4'b1111;
    #1;
    chk("post_rst_ptr_zero", b4.in_ready, 4'b0001);
    step();
    chk("post_rst_rr_src", b4.out_src, 0);
    chk("post_rst_rr_data", b4.out_data, 8'hA0);
    b4.in_valid = 4'b0000;
    b3.mode = 1'b0; b3.sel = 2'd3; b3.in_valid = 3'b111;
    #1;
    chk("n3_sel3_in_ready", b3.in_ready, 3'b000);
    step();
    chk("n3_sel3_out_valid", b3.out_valid, 0);
    b3.mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("n3_rr%0d_in_ready", k), b3.in_ready, 3'b001 << (k % 3));
      step();
      chk($sformatf("n3_rr%0d_out_src", k), b3.out_src, k % 3);
      chk($sformatf("n3_rr%0d_out_valid", k), b3.out_valid, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
